// File: rtl/lane_permuter_pkg.sv
// Shared definitions for the lane permuter: permutation mode encoding and widths.
package lane_permuter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        PASS       = 2'b00,
        SWAP_PAIRS = 2'b01,
        REVERSE    = 2'b10,
        ROTATE     = 2'b11
    } perm_mode_e;

endpackage : lane_permuter_pkg

// File: rtl/lane_pipe_stage.sv
// One pipeline slot of the lane permuter: valid flag plus data word, loaded
// together under a shared advance enable and cleared asynchronously.
module lane_pipe_stage #(
    parameter int DATA_W = 64
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Slot register: load on enable, otherwise hold; data is kept even when invalid.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (i_enable) begin
            valid_r <= i_valid;
            data_r  <= i_data;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign o_valid = valid_r;
    assign o_data  = data_r;

endmodule : lane_pipe_stage

// File: rtl/lane_permuter.sv
// Lane permuter: reorders LANES lanes per beat (pass/swap/reverse/rotate) and
// carries the result through a STAGES-deep, fully stalling valid/ready pipeline.
module lane_permuter
    import lane_permuter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANES  = 4,
    parameter int STAGES = 3
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [LANES*WIDTH-1:0]   i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [MODE_W-1:0]        i_mode,
    input  logic [$clog2(LANES)-1:0] i_rot,
    output logic [LANES*WIDTH-1:0]   o_data,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam int DATA_W = LANES * WIDTH;
    localparam int ROT_W  = $clog2(LANES);

    // Output lane k takes the input lane returned by the mode's index rule.
    function automatic logic [DATA_W-1:0] permute(
        input logic [DATA_W-1:0] din,
        input perm_mode_e        mode,
        input logic [ROT_W-1:0]  rot
    );
        logic [DATA_W-1:0] dout;
        int                src;
        dout = {DATA_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                PASS:       src = k;
                SWAP_PAIRS: src = k ^ 1;
                REVERSE:    src = LANES - 1 - k;
                ROTATE:     src = (k + int'(rot)) % LANES;
                default:    src = k;
            endcase
            dout[k*WIDTH +: WIDTH] = din[src*WIDTH +: WIDTH];
        end
        return dout;
    endfunction

    perm_mode_e                mode_s;
    logic [DATA_W-1:0]         perm_data_s;
    logic                      advance_s;
    logic [STAGES:0]           valid_s;
    logic [STAGES:0][DATA_W-1:0] data_s;

    // Permutation is resolved before the first register, so mode/rot travel with the beat.
    always_comb begin
        mode_s      = perm_mode_e'(i_mode);
        perm_data_s = permute(i_data, mode_s, i_rot);
    end

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign advance_s  = i_ready | ~o_valid;
    assign valid_s[0] = i_valid;
    assign data_s[0]  = perm_data_s;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            lane_pipe_stage #(
                .DATA_W (DATA_W)
            ) u_stage (
                .i_clock   (i_clock),
                .i_reset_n (i_reset_n),
                .i_enable  (advance_s),
                .i_valid   (valid_s[g]),
                .i_data    (data_s[g]),
                .o_valid   (valid_s[g+1]),
                .o_data    (data_s[g+1])
            );
        end
    endgenerate

    assign o_valid = valid_s[STAGES];
    assign o_data  = data_s[STAGES];
    assign o_ready = advance_s;

endmodule : lane_permuter

// File: tb/tb_lane_permuter.sv
// Randomized and directed bench for lane_permuter with a queue-based reference model.
module tb_lane_permuter;

    localparam int WIDTH  = 16;
    localparam int LANES  = 4;
    localparam int STAGES = 3;
    localparam int DW     = WIDTH * LANES;
    localparam int ROT_W  = 2;

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    i_data;
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_mode;
    logic [ROT_W-1:0] i_rot;
    logic [DW-1:0]    o_data;
    logic             o_valid;
    logic             i_ready;

    int vectors     = 0;
    int miscompares = 0;
    int en_count    = 0;
    int seq         = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            adv;
    } exp_t;
    exp_t exp_q[$];

    logic          held_v;
    logic [DW-1:0] held_data;

    lane_permuter #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .STAGES (STAGES)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_mode    (i_mode),
        .i_rot     (i_rot),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out lane k from the mode's lane-index rule.
    function automatic logic [DW-1:0] ref_perm(input logic [DW-1:0] d, input logic [1:0] m,
                                               input logic [ROT_W-1:0] r);
        logic [DW-1:0] o;
        int src;
        o = '0;
        for (int k = 0; k < LANES; k++) begin
            case (m)
                2'd0:    src = k;
                2'd1:    src = k ^ 1;
                2'd2:    src = LANES - 1 - k;
                default: src = (k + int'(r)) % LANES;
            endcase
            o[k*WIDTH +: WIDTH] = d[src*WIDTH +: WIDTH];
        end
        return o;
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare process: order, content, latency in advancing cycles, stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk_bit("ready_rule", o_ready, i_ready | ~o_valid);
            if (held_v) begin
                chk_bit("stall_valid_held", o_valid, 1'b1);
                chk_word("stall_data_held", o_data, held_data);
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk_bit("spurious_beat", o_valid, 1'b0);
                end else begin
                    chk_word("beat_data", o_data, exp_q[0].data);
                    chk_int("beat_latency", en_count, exp_q[0].adv + STAGES - 1);
                    if (i_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && en_count >= exp_q[0].adv + STAGES - 1) begin
                chk_bit("missing_beat", o_valid, 1'b1);
                void'(exp_q.pop_front());
            end
            held_v    = o_valid & ~i_ready;
            held_data = o_data;
            if (i_valid && o_ready) begin
                exp_t e;
                e.data = ref_perm(i_data, i_mode, i_rot);
                e.adv  = en_count + 1;
                exp_q.push_back(e);
            end
            if (o_ready) en_count++;
        end
    end

    // One beat into an idle pipe; o_valid must rise exactly STAGES edges after acceptance.
    task automatic single_beat(input logic [DW-1:0] d, input logic [1:0] m,
                               input logic [ROT_W-1:0] r, input logic [DW-1:0] exp, input string nm);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
        i_rot   = r;
        step();
        i_valid = 1'b0;
        for (int c = 1; c < STAGES; c++) begin
            chk_bit({nm, "_early_valid"}, o_valid, 1'b0);
            step();
        end
        chk_bit({nm, "_valid"}, o_valid, 1'b1);
        chk_word({nm, "_data"}, o_data, exp);
        step();
    endtask

    task automatic run_stream(input int n, input int stall_at, input int stall_len, input bit rnd);
        int  sent;
        int  cyc;
        bit  stall;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 20 * n + 50) begin
            stall   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            i_ready = stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            i_valid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            i_mode  = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
            i_rot   = 2'($urandom_range(0, 3));
            for (int k = 0; k < LANES; k++)
                i_data[k*WIDTH +: WIDTH] = rnd ? WIDTH'($urandom) : WIDTH'(seq * LANES + k);
            #1;
            if (stall && o_valid) chk_bit("stall_o_ready", o_ready, 1'b0);
            if (i_valid && o_ready) begin
                sent++;
                seq++;
            end
            step();
            cyc++;
        end
        chk_int("stream_beats_sent", sent, n);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (STAGES + 2) step();
    endtask

    localparam logic [DW-1:0] BASE = 64'h0003_0002_0001_0000;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_mode  = 2'b00;
        i_rot   = '0;
        i_data  = '0;
        held_v  = 1'b0;
        #12;
        chk_bit("reset_valid", o_valid, 1'b0);
        chk_word("reset_data", o_data, 64'h0);
        chk_bit("reset_ready", o_ready, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Single PASS beat, then back-to-back SWAP/REVERSE/ROTATE with literal expectations.
        single_beat(BASE, 2'b00, 2'd0, 64'h0003_0002_0001_0000, "pass");
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = BASE;
        i_mode  = 2'b01;
        step();
        i_mode  = 2'b10;
        step();
        i_mode  = 2'b11;
        i_rot   = 2'd1;
        step();
        chk_word("b2b_swap", o_data, 64'h0002_0003_0000_0001);
        i_valid = 1'b0;
        step();
        chk_word("b2b_reverse", o_data, 64'h0000_0001_0002_0003);
        step();
        chk_word("b2b_rotate1", o_data, 64'h0000_0003_0002_0001);
        chk_bit("b2b_rotate1_valid", o_valid, 1'b1);
        repeat (STAGES + 1) step();

        // Eight-beat stream with a two-cycle downstream stall.
        run_stream(8, 5, 2, 1'b0);

        // Fill the pipe with downstream blocked, then offer one more beat.
        i_ready = 1'b0;
        for (int b = 0; b < STAGES; b++) begin
            i_valid = 1'b1;
            i_mode  = 2'($urandom_range(0, 3));
            for (int k = 0; k < LANES; k++) i_data[k*WIDTH +: WIDTH] = WIDTH'(16'h0A00 + b * LANES + k);
            #1;
            chk_bit("fill_ready", o_ready, 1'b1);
            step();
        end
        i_data = 64'hBEEF_CAFE_1234_5678;
        i_mode = 2'b10;
        repeat (3) begin
            #1;
            chk_bit("full_o_ready", o_ready, 1'b0);
            chk_bit("full_o_valid", o_valid, 1'b1);
            step();
        end
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (STAGES + 2) step();

        // Asynchronous reset in the middle of a stream.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_mode  = 2'b00;
        repeat (5) begin
            i_data = {$urandom, $urandom};
            step();
        end
        chk_bit("pre_reset_valid", o_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_reset_valid", o_valid, 1'b0);
        chk_word("async_reset_data", o_data, 64'h0);
        chk_bit("async_reset_ready", o_ready, 1'b1);
        i_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        single_beat(BASE, 2'b11, 2'd2, 64'h0001_0000_0003_0002, "post_reset");

        // Random stream: random valid/ready, mode and rotate change every cycle.
        run_stream(400, -10, 0, 1'b1);

        chk_int("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1);
    end

endmodule : tb_lane_permuter
